oric_sdram_arbiter: RTL

Shares the single SDRAM controller port between the Oric CPU/ULA RAM interface and the FDC disk-image buffer. It runs on clk_72 and converts the CPU's level-style strobes and the FDC's request pulses into the SDRAM controller's toggle req/ack handshake. CPU accesses have fixed priority; a starvation limit bounds FDC latency. It sits between the core's ram_* signals and the SDRAM controller's port1.

---
 rtl/oric_sdram_arbiter.sv | 129 ++++++++++++
 1 files changed

// File: rtl/oric_sdram_arbiter.sv
// oric_sdram_arbiter: shares the SDRAM controller toggle port between the Oric CPU and the FDC disk buffer
module oric_sdram_arbiter #(
  parameter logic [23:0] FDC_BASE = 24'h010000,
  parameter int FDC_STARVE = 4
) (
  input  logic        clk_72,
  input  logic        reset,
  input  logic        cpu_cs,
  input  logic        cpu_oe,
  input  logic        cpu_we,
  input  logic [15:0] cpu_a,
  input  logic [7:0]  cpu_d,
  output logic [7:0]  cpu_q,
  input  logic        fdc_req,
  input  logic        fdc_we,
  input  logic [17:0] fdc_a,
  input  logic [7:0]  fdc_d,
  output logic [7:0]  fdc_q,
  output logic        fdc_ack,
  output logic        fdc_overrun,
  output logic        mem_req,
  input  logic        mem_ack,
  output logic [23:0] mem_a,
  output logic [1:0]  mem_ds,
  output logic        mem_we,
  output logic [15:0] mem_d,
  input  logic [15:0] mem_q,
  output logic        busy
);
  localparam logic [3:0] STARVE_MAX = 4'(FDC_STARVE);
  typedef enum logic [1:0] {DRAIN, IDLE, CPU_WAIT, FDC_WAIT} state_t;
  state_t state, state_nx;
  logic mem_req_r = 1'b0;
  logic prev_rd, prev_wr;
  logic [15:0] prev_a;
  logic cpu_pend, fdc_pend;
  logic [15:0] cpu_a_l;
  logic [7:0] cpu_d_l, fdc_d_l;
  logic cpu_we_l, fdc_we_l;
  logic [17:0] fdc_a_l;
  logic [3:0] starve_cnt;
  logic lane_hi;
  logic cpu_rd, cpu_wr, cpu_ev, ack_match, fdc_drop, fdc_win, cpu_win;
  logic g_we, g_a0;
  logic [7:0] g_d, rd_byte;
  assign cpu_rd = cpu_cs & cpu_oe;
  assign cpu_wr = cpu_cs & cpu_we;
  assign cpu_ev = (cpu_rd & ~prev_rd) | (cpu_wr & ~prev_wr) | (cpu_rd & (cpu_a != prev_a));
  assign ack_match = mem_ack == mem_req_r;
  assign fdc_drop = fdc_req & (fdc_pend | (state == FDC_WAIT & ~ack_match));
  assign fdc_win = state == IDLE & fdc_pend & (starve_cnt == STARVE_MAX | ~cpu_pend);
  assign cpu_win = state == IDLE & cpu_pend & ~fdc_win;
  assign g_we = fdc_win ? fdc_we_l : cpu_we_l;
  assign g_a0 = fdc_win ? fdc_a_l[0] : cpu_a_l[0];
  assign g_d = fdc_win ? fdc_d_l : cpu_d_l;
  assign rd_byte = lane_hi ? mem_q[15:8] : mem_q[7:0];
  assign mem_req = mem_req_r;
  assign busy = state != IDLE;
  // State register; reset lands in DRAIN so a stale acknowledge is absorbed
  always_ff @(posedge clk_72)
    state <= reset ? DRAIN : state_nx;
  // Next state: grant from IDLE, every waiting state returns to IDLE on matching ack
  always_comb begin
    state_nx = state;
    if (state == IDLE) state_nx = fdc_win ? FDC_WAIT : cpu_win ? CPU_WAIT : IDLE;
    else if (ack_match) state_nx = IDLE;
  end
  // Strobe history for edge and address-change detection, tracked through reset
  always_ff @(posedge clk_72) begin
    prev_rd <= cpu_rd;
    prev_wr <= cpu_wr;
    prev_a <= cpu_a;
  end
  // Request latches; latest CPU event wins, FDC keeps the first request
  always_ff @(posedge clk_72) begin
    if (cpu_ev) begin
      cpu_a_l <= cpu_a;
      cpu_d_l <= cpu_d;
      cpu_we_l <= cpu_we;
    end
    if (fdc_req & ~fdc_drop) begin
      fdc_a_l <= fdc_a;
      fdc_d_l <= fdc_d;
      fdc_we_l <= fdc_we;
    end
  end
  // Pending flags, overrun flag and FDC starvation counter
  always_ff @(posedge clk_72) begin
    if (reset) begin
      cpu_pend <= 1'b0;
      fdc_pend <= 1'b0;
      fdc_overrun <= 1'b0;
      starve_cnt <= 4'd0;
    end else begin
      cpu_pend <= cpu_ev | (cpu_pend & ~cpu_win);
      fdc_pend <= (fdc_req & ~fdc_drop) | (fdc_pend & ~fdc_win);
      fdc_overrun <= fdc_overrun | fdc_drop;
      starve_cnt <= fdc_win ? 4'd0 :
                    (cpu_win & fdc_pend & starve_cnt != STARVE_MAX) ? starve_cnt + 4'd1 : starve_cnt;
    end
  end
  // Toggle request on every grant; never touched by reset so DRAIN can match the ack
  always_ff @(posedge clk_72)
    mem_req_r <= mem_req_r ^ ((cpu_win | fdc_win) & ~reset);
  // Issue registers held stable for the whole transaction, plus read-data capture
  always_ff @(posedge clk_72) begin
    if (reset) begin
      mem_a <= 24'd0;
      mem_ds <= 2'b11;
      mem_we <= 1'b0;
      mem_d <= 16'd0;
      lane_hi <= 1'b0;
      cpu_q <= 8'd0;
      fdc_q <= 8'd0;
      fdc_ack <= 1'b0;
    end else begin
      fdc_ack <= state == FDC_WAIT & ack_match;
      if (cpu_win | fdc_win) begin
        mem_a <= fdc_win ? FDC_BASE + {6'b0, fdc_a_l} : {8'h00, cpu_a_l};
        mem_ds <= g_we ? (g_a0 ? 2'b10 : 2'b01) : 2'b11;
        mem_we <= g_we;
        mem_d <= {g_d, g_d};
        lane_hi <= g_a0;
      end
      if (state == CPU_WAIT & ack_match & ~mem_we) cpu_q <= rd_byte;
      if (state == FDC_WAIT & ack_match & ~mem_we) fdc_q <= rd_byte;
    end
  end
endmodule
